ddr3_cmd_rx: RTL and testbench

// - Device-side receiver for the controller's DDR3 command bus (ras_n/cas_n/we_n/ba/addr); front end of the TB DDR3 model.
// - Registers and decodes each command, tracks per-bank open-row state, and checks tRCD/tRP/tRAS/tRFC plus protocol legality.
// - Emits decoded-command pulses, error flags and a CL-delayed read-return strobe for the data model and scoreboard.

---
 rtl/ddr3_cmd_rx.sv | 217 +++++++++++++++++++++
 tb/tb_ddr3_cmd_rx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_rx.sv
// DDR3 command-bus receiver for the TB memory model: decodes each command, tracks per-bank
// row state and tRCD/tRP/tRAS/tRFC timing, flags protocol errors and returns reads after CL.
package ddr3_cmd_rx_pkg;
   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4
   } ddr3_cmd_t;

   typedef struct packed {
      logic        valid;
      logic [1:0]  ba;
      logic [12:0] col;
   } rd_ent_t;
endpackage

module ddr3_cmd_rx
   import ddr3_cmd_rx_pkg::*;
#(
   parameter int T_RCD = 3,
   parameter int T_RP  = 3,
   parameter int T_RAS = 8,
   parameter int T_RFC = 20,
   parameter int CL    = 5    // legal range 2..16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ddr3_ras_n,
   input  logic        ddr3_cas_n,
   input  logic        ddr3_we_n,
   input  logic [1:0]  ddr3_ba,
   input  logic [12:0] ddr3_addr,
   input  logic        err_clr,
   output logic        cmd_valid,
   output ddr3_cmd_t   cmd_type,
   output logic        cmd_refresh,
   output logic [1:0]  cmd_ba,
   output logic [12:0] cmd_addr,
   output logic [3:0]  bank_open,
   output logic        rd_valid,
   output logic [1:0]  rd_ba,
   output logic [12:0] rd_col,
   output logic [7:0]  err_pulse,
   output logic [7:0]  err_sticky
);

   localparam int T_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int T_MAX_B = (T_RAS > T_RFC) ? T_RAS : T_RFC;
   localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int CW      = $clog2(T_MAX) + 1;

   localparam logic [CW-1:0] CNT_SAT = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] RCD_C   = CW'(T_RCD);
   localparam logic [CW-1:0] RP_C    = CW'(T_RP);
   localparam logic [CW-1:0] RAS_C   = CW'(T_RAS);
   localparam logic [CW-1:0] RFC_C   = CW'(T_RFC);

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_ACTIVATING  = 2'd1;
   localparam logic [1:0] ST_ACTIVE      = 2'd2;
   localparam logic [1:0] ST_PRECHARGING = 2'd3;

   // Counters hold "edges since the last accepted ACT/PRE/REF", saturating so that
   // an untouched bank always reads as having met every constraint.
   logic [1:0]    bank_st [4];
   logic [CW-1:0] act_cnt [4];
   logic [CW-1:0] pre_cnt [4];
   logic [CW-1:0] ref_cnt;
   rd_ent_t       rd_pipe [CL];

   logic [2:0]  pins;
   logic        is_act, is_rd, is_wr, is_pre, is_ref, is_ill, is_nop;
   ddr3_cmd_t   type_d;
   logic [7:0]  err_d;
   logic [3:0]  pre_sel;
   logic        accept;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_SAT) ? v : v + CNT_ONE;
   endfunction

   function automatic logic row_busy(input logic [1:0] st);
      return (st == ST_ACTIVATING) || (st == ST_ACTIVE);
   endfunction

   assign pins = {ddr3_ras_n, ddr3_cas_n, ddr3_we_n};

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      is_act = 1'b0;
      is_rd  = 1'b0;
      is_wr  = 1'b0;
      is_pre = 1'b0;
      is_ref = 1'b0;
      is_ill = 1'b0;
      is_nop = 1'b0;
      type_d = CMD_NOP;
      case (pins)
         3'b011:  begin is_act = 1'b1; type_d = CMD_ACT; end
         3'b101:  begin is_rd  = 1'b1; type_d = CMD_RD;  end
         3'b100:  begin is_wr  = 1'b1; type_d = CMD_WR;  end
         3'b010:  begin is_pre = 1'b1; type_d = CMD_PRE; end
         3'b001:  is_ref = 1'b1;
         3'b111:  is_nop = 1'b1;
         default: is_ill = 1'b1;
      endcase
   end

   always_comb begin
      err_d   = '0;
      pre_sel = '0;
      if (!is_nop && (ref_cnt < RFC_C)) err_d[3] = 1'b1;
      if (is_act) begin
         if (row_busy(bank_st[ddr3_ba])) err_d[4] = 1'b1;
         if (pre_cnt[ddr3_ba] < RP_C)    err_d[1] = 1'b1;
      end
      if (is_rd || is_wr) begin
         if (!row_busy(bank_st[ddr3_ba]))    err_d[5] = 1'b1;
         else if (act_cnt[ddr3_ba] < RCD_C)  err_d[0] = 1'b1;
      end
      // PRE only acts on banks with a row open; idle/precharging targets are silent no-ops.
      if (is_pre) begin
         for (int b = 0; b < 4; b++) begin
            if (ddr3_addr[10] || (ddr3_ba == 2'(b))) pre_sel[b] = row_busy(bank_st[b]);
            if (pre_sel[b] && (act_cnt[b] < RAS_C)) err_d[2] = 1'b1;
         end
      end
      if (is_ref) begin
         for (int b = 0; b < 4; b++) begin
            if (bank_st[b] != ST_IDLE) err_d[6] = 1'b1;
         end
      end
      if (is_ill) err_d[7] = 1'b1;
   end

   assign accept = !is_nop && (err_d == '0);

   // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 4; b++) begin
            bank_st[b] <= ST_IDLE;
            act_cnt[b] <= CNT_SAT;
            pre_cnt[b] <= CNT_SAT;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            act_cnt[b] <= sat_inc(act_cnt[b]);
            pre_cnt[b] <= sat_inc(pre_cnt[b]);
            if (accept && is_act && (ddr3_ba == 2'(b))) begin
               act_cnt[b] <= CNT_ONE;
               bank_st[b] <= (RCD_C <= CNT_ONE) ? ST_ACTIVE : ST_ACTIVATING;
            end else if (accept && pre_sel[b]) begin
               pre_cnt[b] <= CNT_ONE;
               bank_st[b] <= (RP_C <= CNT_ONE) ? ST_IDLE : ST_PRECHARGING;
            end else if ((bank_st[b] == ST_ACTIVATING) && (sat_inc(act_cnt[b]) >= RCD_C)) begin
               bank_st[b] <= ST_ACTIVE;
            end else if ((bank_st[b] == ST_PRECHARGING) && (sat_inc(pre_cnt[b]) >= RP_C)) begin
               bank_st[b] <= ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt <= CNT_SAT;
      end else if (accept && is_ref) begin
         ref_cnt <= CNT_ONE;
      end else begin
         ref_cnt <= sat_inc(ref_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid   <= 1'b0;
         cmd_type    <= CMD_NOP;
         cmd_refresh <= 1'b0;
         cmd_ba      <= '0;
         cmd_addr    <= '0;
         err_pulse   <= '0;
         err_sticky  <= '0;
      end else begin
         cmd_valid   <= !is_nop;
         cmd_type    <= type_d;
         cmd_refresh <= is_ref;
         cmd_ba      <= is_nop ? 2'b00 : ddr3_ba;
         cmd_addr    <= is_nop ? 13'h0 : ddr3_addr;
         err_pulse   <= err_d;
         err_sticky  <= err_clr ? 8'h00 : (err_sticky | err_d);
      end
   end

   // NOTE: the whole read pipe is reset, not just the valid bits, so in-flight reads
   // vanish on reset and the rd_* outputs read zero afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CL; i++) rd_pipe[i] <= '0;
      end else begin
         rd_pipe[0] <= (accept && is_rd) ? rd_ent_t'{1'b1, ddr3_ba, ddr3_addr} : '0;
         for (int i = 1; i < CL; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   assign rd_valid = rd_pipe[CL-1].valid;
   assign rd_ba    = rd_pipe[CL-1].ba;
   assign rd_col   = rd_pipe[CL-1].col;

   always_comb begin
      for (int b = 0; b < 4; b++) bank_open[b] = (bank_st[b] == ST_ACTIVE);
   end

endmodule

// File: tb/tb_ddr3_cmd_rx.sv
// Self-checking bench for ddr3_cmd_rx: directed protocol scenarios plus random traffic,
// compared every cycle against a time-stamp based model of the command rules.
module tb_ddr3_cmd_rx;
   import ddr3_cmd_rx_pkg::*;

   localparam int T_RCD = 3;
   localparam int T_RP  = 3;
   localparam int T_RAS = 8;
   localparam int T_RFC = 20;
   localparam int CL    = 5;

   localparam logic [2:0] C_ACT  = 3'b011;
   localparam logic [2:0] C_RD   = 3'b101;
   localparam logic [2:0] C_WR   = 3'b100;
   localparam logic [2:0] C_PRE  = 3'b010;
   localparam logic [2:0] C_REF  = 3'b001;
   localparam logic [2:0] C_NOP  = 3'b111;
   localparam logic [2:0] C_ILL0 = 3'b000;
   localparam logic [2:0] C_ILL1 = 3'b110;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [1:0]  ba = '0;
   logic [12:0] addr = '0;
   logic        err_clr = 1'b0;

   logic        cmd_valid, cmd_refresh, rd_valid;
   ddr3_cmd_t   cmd_type;
   logic [1:0]  cmd_ba, rd_ba;
   logic [12:0] cmd_addr, rd_col;
   logic [3:0]  bank_open;
   logic [7:0]  err_pulse, err_sticky;

   ddr3_cmd_rx #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC), .CL(CL)) dut (
      .clk(clk), .rst_n(rst_n),
      .ddr3_ras_n(ras_n), .ddr3_cas_n(cas_n), .ddr3_we_n(we_n),
      .ddr3_ba(ba), .ddr3_addr(addr), .err_clr(err_clr),
      .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_refresh(cmd_refresh),
      .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .bank_open(bank_open),
      .rd_valid(rd_valid), .rd_ba(rd_ba), .rd_col(rd_col),
      .err_pulse(err_pulse), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: absolute edge time stamps ----------------
   typedef struct {
      int          due;
      logic [1:0]  ba;
      logic [12:0] col;
   } rd_exp_t;

   int        e = 0;
   bit        m_open [4];
   int        t_act [4];
   int        t_pre [4];
   int        t_ref;
   rd_exp_t   rq [$];

   logic        x_valid, x_refresh, x_rv;
   ddr3_cmd_t   x_type;
   logic [1:0]  x_ba, x_rba;
   logic [12:0] x_addr, x_rcol;
   logic [3:0]  x_open;
   logic [7:0]  x_err, x_sticky;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_open[k] = 1'b0;
         t_act[k]  = -1000;
         t_pre[k]  = -1000;
      end
      t_ref = -1000;
      rq.delete();
      x_valid = 0; x_refresh = 0; x_rv = 0; x_type = CMD_NOP;
      x_ba = 0; x_rba = 0; x_addr = 0; x_rcol = 0; x_open = 0; x_err = 0; x_sticky = 0;
   endtask

   task automatic model_step(input logic [2:0] code, input logic [1:0] cb, input logic [12:0] ca,
                             input logic clr);
      logic [7:0] err;
      int         b;
      bit         nonnop;
      err    = '0;
      b      = int'(cb);
      nonnop = (code != C_NOP);
      if (nonnop && (e - t_ref < T_RFC)) err[3] = 1'b1;
      case (code)
         C_ACT: begin
            if (m_open[b]) err[4] = 1'b1;
            if (e - t_pre[b] < T_RP) err[1] = 1'b1;
         end
         C_RD, C_WR: begin
            if (!m_open[b]) err[5] = 1'b1;
            else if (e - t_act[b] < T_RCD) err[0] = 1'b1;
         end
         C_PRE: begin
            for (int k = 0; k < 4; k++)
               if ((ca[10] || k == b) && m_open[k] && (e - t_act[k] < T_RAS)) err[2] = 1'b1;
         end
         C_REF: begin
            for (int k = 0; k < 4; k++)
               if (m_open[k] || (e - t_pre[k] < T_RP)) err[6] = 1'b1;
         end
         C_NOP: ;
         default: err[7] = 1'b1;
      endcase
      if (nonnop && err == 0) begin
         case (code)
            C_ACT: begin m_open[b] = 1'b1; t_act[b] = e; end
            C_RD:  rq.push_back('{e + CL - 1, cb, ca});
            C_PRE: begin
               for (int k = 0; k < 4; k++)
                  if ((ca[10] || k == b) && m_open[k]) begin
                     m_open[k] = 1'b0;
                     t_pre[k]  = e;
                  end
            end
            C_REF: t_ref = e;
            default: ;
         endcase
      end
      x_valid   = nonnop;
      x_refresh = (code == C_REF);
      case (code)
         C_ACT:   x_type = CMD_ACT;
         C_RD:    x_type = CMD_RD;
         C_WR:    x_type = CMD_WR;
         C_PRE:   x_type = CMD_PRE;
         default: x_type = CMD_NOP;
      endcase
      x_ba     = nonnop ? cb : 2'b00;
      x_addr   = nonnop ? ca : 13'h0;
      x_err    = err;
      x_sticky = clr ? 8'h00 : (x_sticky | err);
      for (int k = 0; k < 4; k++) x_open[k] = m_open[k] && (e + 1 - t_act[k] >= T_RCD);
      x_rv = 0; x_rba = 0; x_rcol = 0;
      if (rq.size() > 0 && rq[0].due == e) begin
         x_rv   = 1'b1;
         x_rba  = rq[0].ba;
         x_rcol = rq[0].col;
         void'(rq.pop_front());
      end
   endtask

   // One compare process: model advances on each edge, DUT checked 1 ns later.
   always @(posedge clk) begin
      e++;
      if (!rst_n) model_reset();
      else model_step({ras_n, cas_n, we_n}, ba, addr, err_clr);
      #1;
      check("cmd_valid",   64'(cmd_valid),   64'(x_valid));
      check("cmd_type",    64'(cmd_type),    64'(x_type));
      check("cmd_refresh", 64'(cmd_refresh), 64'(x_refresh));
      check("cmd_ba",      64'(cmd_ba),      64'(x_ba));
      check("cmd_addr",    64'(cmd_addr),    64'(x_addr));
      check("bank_open",   64'(bank_open),   64'(x_open));
      check("err_pulse",   64'(err_pulse),   64'(x_err));
      check("err_sticky",  64'(err_sticky),  64'(x_sticky));
      check("rd_valid",    64'(rd_valid),    64'(x_rv));
      check("rd_ba",       64'(rd_ba),       64'(x_rba));
      check("rd_col",      64'(rd_col),      64'(x_rcol));
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [2:0] code, input logic [1:0] b, input logic [12:0] a,
                        input logic clr);
      @(negedge clk);
      {ras_n, cas_n, we_n} = code;
      ba      = b;
      addr    = a;
      err_clr = clr;
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [2:0] code, input logic [1:0] b, input logic [12:0] a);
      drive(code, b, a, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(C_NOP, 2'd0, 13'h0, 1'b0);
   endtask

   task automatic assert_reset();
      @(negedge clk);
      rst_n = 1'b0;
      {ras_n, cas_n, we_n} = C_NOP;
      ba = '0; addr = '0; err_clr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [12:0] cols [$];
      int          idx [$];
      int          seen;
      logic [2:0]  code;
      logic [12:0] a;
      int          r;

      repeat (3) @(negedge clk);
      #1;
      check("rst_cmd_valid",  64'(cmd_valid),  64'd0);
      check("rst_bank_open",  64'(bank_open),  64'd0);
      check("rst_rd_valid",   64'(rd_valid),   64'd0);
      check("rst_err_sticky", 64'(err_sticky), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // ACT b1, RD after exactly tRCD, read returns CL later
      issue(C_ACT, 2'd1, 13'h1A5);
      check("act_type", 64'(cmd_type), 64'(CMD_ACT));
      check("act_addr", 64'(cmd_addr), 64'h1A5);
      check("act_err",  64'(err_pulse), 64'h00);
      idle(1);
      check("open_early", 64'(bank_open), 64'h0);
      idle(1);
      check("open_t0p3", 64'(bank_open), 64'h2);
      issue(C_RD, 2'd1, 13'h008);
      check("rd_err",  64'(err_pulse), 64'h00);
      check("rd_type", 64'(cmd_type), 64'(CMD_RD));
      idle(CL - 2);
      check("rd_not_yet", 64'(rd_valid), 64'd0);
      idle(1);
      check("rd_ret_valid", 64'(rd_valid), 64'd1);
      check("rd_ret_ba",    64'(rd_ba),    64'd1);
      check("rd_ret_col",   64'(rd_col),   64'h08);

      // tRCD violation, sticky hold and clear priority
      issue(C_ACT, 2'd0, 13'h010);
      idle(1);
      issue(C_RD, 2'd0, 13'h020);
      check("trcd_err", 64'(err_pulse), 64'h01);
      check("trcd_sticky", 64'(err_sticky), 64'h01);
      idle(CL + 1);
      check("sticky_hold", 64'(err_sticky), 64'h01);
      drive(C_NOP, 2'd0, 13'h0, 1'b1);
      check("sticky_clr", 64'(err_sticky), 64'h00);
      drive(C_RD, 2'd2, 13'h0, 1'b1);
      check("clr_pulse", 64'(err_pulse), 64'h20);
      check("clr_wins",  64'(err_sticky), 64'h00);

      // tRAS then tRP on bank 2
      issue(C_ACT, 2'd2, 13'h055);
      idle(6);
      issue(C_PRE, 2'd2, 13'h0);
      check("tras_err", 64'(err_pulse), 64'h04);
      issue(C_PRE, 2'd2, 13'h0);
      check("pre_ok", 64'(err_pulse), 64'h00);
      idle(1);
      issue(C_ACT, 2'd2, 13'h066);
      check("trp_err", 64'(err_pulse), 64'h02);
      issue(C_ACT, 2'd2, 13'h066);
      check("act_ok", 64'(err_pulse), 64'h00);

      // PRE-all with banks 0,2 open, then REF / tRFC
      issue(C_PRE, 2'd1, 13'h0);
      idle(8);
      issue(C_PRE, 2'd0, 13'h400);
      check("preall_err",  64'(err_pulse), 64'h00);
      check("preall_open", 64'(bank_open), 64'h0);
      idle(1);
      issue(C_REF, 2'd0, 13'h0);
      check("ref_precharging", 64'(err_pulse), 64'h40);
      issue(C_REF, 2'd0, 13'h0);
      check("ref_ok",      64'(err_pulse),   64'h00);
      check("ref_flag",    64'(cmd_refresh), 64'd1);
      check("ref_type",    64'(cmd_type),    64'(CMD_NOP));
      idle(18);
      issue(C_ACT, 2'd3, 13'h077);
      check("trfc_err", 64'(err_pulse), 64'h08);
      issue(C_ACT, 2'd3, 13'h077);
      check("trfc_ok", 64'(err_pulse), 64'h00);
      idle(3);
      issue(C_REF, 2'd0, 13'h0);
      check("ref_open_err", 64'(err_pulse), 64'h40);

      // illegal encodings
      issue(C_ILL0, 2'd0, 13'h0);
      check("ill000", 64'(err_pulse), 64'h80);
      issue(C_ILL1, 2'd0, 13'h0);
      check("ill110", 64'(err_pulse), 64'h80);
      check("ill_valid", 64'(cmd_valid), 64'd1);

      // back-to-back reads across banks 3,0,1,3
      issue(C_ACT, 2'd0, 13'h001);
      issue(C_ACT, 2'd1, 13'h002);
      idle(3);
      issue(C_RD, 2'd3, 13'h011);
      issue(C_RD, 2'd0, 13'h022);
      issue(C_RD, 2'd1, 13'h033);
      issue(C_RD, 2'd3, 13'h044);
      for (int i = 0; i < CL + 4; i++) begin
         idle(1);
         if (rd_valid) begin
            cols.push_back(rd_col);
            idx.push_back(i);
         end
      end
      check("b2b_count", 64'(cols.size()), 64'd4);
      if (cols.size() == 4) begin
         check("b2b_col0", 64'(cols[0]), 64'h11);
         check("b2b_col1", 64'(cols[1]), 64'h22);
         check("b2b_col2", 64'(cols[2]), 64'h33);
         check("b2b_col3", 64'(cols[3]), 64'h44);
         check("b2b_span", 64'(idx[3] - idx[0]), 64'd3);
      end
      issue(C_WR, 2'd0, 13'h099);

      // reset with reads in flight
      issue(C_RD, 2'd0, 13'h055);
      issue(C_RD, 2'd1, 13'h066);
      assert_reset();
      #1;
      check("midrst_rd_valid",  64'(rd_valid),  64'd0);
      check("midrst_bank_open", 64'(bank_open), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < CL + 2; i++) begin
         idle(1);
         seen += int'(rd_valid);
      end
      check("midrst_no_rd", 64'(seen), 64'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            assert_reset();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
         r = $urandom_range(0, 99);
         if (r < 35)      code = C_NOP;
         else if (r < 52) code = C_ACT;
         else if (r < 68) code = C_RD;
         else if (r < 76) code = C_WR;
         else if (r < 88) code = C_PRE;
         else if (r < 93) code = C_REF;
         else if (r < 95) code = C_ILL0;
         else if (r < 97) code = C_ILL1;
         else             code = C_NOP;
         a = 13'($urandom);
         if (code == C_PRE) a[10] = ($urandom_range(0, 3) == 0);
         drive(code, 2'($urandom_range(0, 3)), a, ($urandom_range(0, 31) == 0));
      end
      idle(CL + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
